operand_sequencer: RTL and testbench
====================================

Name: operand_sequencer

Overview:
- Parametrised operand/command sequencer between the narrow board switch bus and the arithmetic core in top.
- Assembles N_OPS operands of OP_W bits from successive IN_W-bit input beats, low chunk first, then a command beat.
- Issues operands and command to the core over a valid/ready handshake, waits for the core's result and holds it for the display path.
- Generalises the fixed two-operand, two-half-word entry sequence to any width, chunk count and operand count, and adds abort and result-hold behaviour.

Parameters:
- IN_W, 16, width of one input beat; OP_W must be an integer multiple of it.
- OP_W, 32, operand and result width.
- N_OPS, 2, number of operands collected per operation (at least 1).
- CMD_W, 5, command width, taken from din[CMD_W-1:0] of the command beat (CMD_W at most IN_W).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- din  in  IN_W  input beat (switches).
- din_valid  in  1  single-cycle strobe; accept din this cycle.
- clear  in  1  synchronous abort; return to LOAD.
- op_bus  out  N_OPS*OP_W  operands; operand k occupies bits [k*OP_W +: OP_W].
- cmd  out  CMD_W  latched command.
- out_valid  out  1  operands and cmd offered to the core.
- out_ready  in  1  core accepts the offer.
- res  in  OP_W  core result.
- res_valid  in  1  result strobe from the core.
- result  out  OP_W  held result.
- result_valid  out  1  result holds a completed operation.
- busy  out  1  high in ISSUE or WAIT.
- beat_idx  out  clog2(N_OPS*OP_W/IN_W+1)  beats accepted in the current load.

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high. It sets state to LOAD and clears op_bus, cmd, result, result_valid, out_valid, busy and beat_idx to 0.
- CHUNKS = OP_W/IN_W. TOTAL = N_OPS*CHUNKS data beats.
- Beat b (counted from 0) writes din into operand b/CHUNKS, chunk b%CHUNKS, at bits [(b%CHUNKS)*IN_W +: IN_W].
- Each accepted beat updates op_bus on the next edge. Other bits of op_bus hold their value.
- States:
  - LOAD: each din_valid writes one chunk and increments beat_idx. When beat_idx==TOTAL, the next din_valid latches cmd from din[CMD_W-1:0], goes to ISSUE and resets beat_idx to 0.
  - ISSUE: out_valid=1. op_bus and cmd are stable. When out_valid && out_ready on a rising edge, go to WAIT; out_valid drops on the next cycle.
  - WAIT: on res_valid, latch result=res, set result_valid=1 and go to DONE.
  - DONE: result and result_valid hold. The next din_valid clears result_valid, is accepted as beat 0 of a new load, and moves the block to LOAD.
- out_valid rises the cycle after the command beat is accepted. result_valid rises the cycle after res_valid.
- If out_ready is already high, ISSUE lasts exactly one cycle.
- Priority: rst > clear > din_valid/handshake.
- clear in LOAD, ISSUE or WAIT: go to LOAD, beat_idx=0, out_valid=0, busy=0. op_bus and cmd are not cleared.
- clear leaves result and result_valid unchanged. In DONE, clear goes to LOAD and keeps result_valid=1 until the next din_valid.
- A res_valid arriving after an abort is ignored.
- Ignored inputs:
  - din_valid during ISSUE or WAIT (no state change).
  - res_valid outside WAIT.
  - out_ready outside ISSUE.
- busy = (state==ISSUE || state==WAIT), registered.
- A din_valid in the same cycle as clear is dropped.
- A res_valid in the same cycle as out_ready in ISSUE is ignored. The result must come strictly in WAIT.
- Load has no timeout. beat_idx never exceeds TOTAL.

Test Plan:
- Defaults, beats 0x0000, 0x40A8, 0x0000, 0x4194, then cmd beat 0x0008 -> op_bus=0x4194_0000_40A8_0000, cmd=0x08, out_valid high one cycle after the cmd beat; out_ready=1 -> WAIT.
- In WAIT, res=0x41BE_0000 with res_valid -> next cycle result=0x41BE_0000, result_valid=1, busy=0. The next beat 0x1234 clears result_valid, writes op0 low chunk=0x1234, beat_idx=1.
- Hold out_ready=0 for 5 cycles in ISSUE while pulsing din_valid and res_valid -> out_valid stays 1, op_bus/cmd unchanged, no state change; out_ready=1 -> WAIT.
- clear after 3 beats -> beat_idx=0, state LOAD, prior result/result_valid retained. A full reload of 4 beats plus cmd issues normally.
- rst asserted in WAIT -> next cycle all outputs 0; a later res_valid is ignored and result stays 0.
- Parameter sweep IN_W=8, OP_W=32, N_OPS=3 -> 12 data beats plus 1 cmd beat; beats 0x01..0x0C give op_bus=0x0C0B0A09_08070605_04030201.

Source files
------------

// File: rtl/operand_sequencer.sv
// operand_sequencer: assembles N_OPS operands from IN_W-bit beats plus a command, issues them over valid/ready and holds the core result.
module operand_sequencer #(
  parameter int IN_W = 16,
  parameter int OP_W = 32,
  parameter int N_OPS = 2,
  parameter int CMD_W = 5,
  localparam int TOTAL = N_OPS * (OP_W / IN_W),
  localparam int BW = $clog2(TOTAL + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       din,
  input  logic                  din_valid,
  input  logic                  clear,
  output logic [N_OPS*OP_W-1:0] op_bus,
  output logic [CMD_W-1:0]      cmd,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [OP_W-1:0]       res,
  input  logic                  res_valid,
  output logic [OP_W-1:0]       result,
  output logic                  result_valid,
  output logic                  busy,
  output logic [BW-1:0]         beat_idx
);
  typedef enum logic [1:0] {LOAD, ISSUE, WAIT, DONE} state_t;
  state_t r_state, w_next;
  logic w_take, w_cmd;
  logic [BW-1:0] w_b;
  // chunk c of operand k sits at (k*CHUNKS + c)*IN_W, so the beat index alone gives the offset
  assign w_take = !clear && din_valid && ((r_state == LOAD && beat_idx != BW'(TOTAL)) || r_state == DONE);
  assign w_cmd  = !clear && din_valid && r_state == LOAD && beat_idx == BW'(TOTAL);
  assign w_b    = r_state == DONE ? '0 : beat_idx;
  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    w_next = w_cmd ? ISSUE : LOAD;
      ISSUE:   w_next = out_ready ? WAIT : ISSUE;
      WAIT:    w_next = res_valid ? DONE : WAIT;
      default: w_next = din_valid ? LOAD : DONE;
    endcase
    if (clear) w_next = LOAD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= LOAD;
      op_bus       <= '0;
      cmd          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      beat_idx     <= '0;
    end else begin
      r_state   <= w_next;
      out_valid <= w_next == ISSUE;
      busy      <= w_next == ISSUE || w_next == WAIT;
      if (w_take) begin
        op_bus[w_b*IN_W +: IN_W] <= din;
        beat_idx                 <= w_b + 1'b1;
      end
      if (w_cmd) begin
        cmd      <= din[CMD_W-1:0];
        beat_idx <= '0;
      end
      if (clear) beat_idx <= '0;
      if (w_take || w_cmd) result_valid <= 1'b0;
      if (r_state == WAIT && res_valid && !clear) begin
        result       <= res;
        result_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: directed and random stimulus checked every cycle against a chunk-array reference model.
module tb_operand_sequencer;
  logic clk = 1'b0;
  logic rst, din_valid, clear, out_ready, res_valid;
  logic [15:0] din;
  logic [31:0] res;
  logic [63:0] op_bus;
  logic [4:0] cmd;
  logic out_valid, result_valid, busy;
  logic [31:0] result;
  logic [2:0] beat_idx;
  logic [7:0] din8;
  logic dv8;
  logic [95:0] op8;
  logic [4:0] cmd8;
  logic ov8, rv8, busy8;
  logic [31:0] result8;
  logic [3:0] bi8;
  int ph, m_n, total, passed;
  logic [15:0] m_ch [4];
  logic [4:0] m_cmd;
  logic [31:0] m_res;
  logic m_rv;

  always #5 clk = ~clk;

  operand_sequencer u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
    .op_bus(op_bus), .cmd(cmd), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .res_valid(res_valid), .result(result), .result_valid(result_valid),
    .busy(busy), .beat_idx(beat_idx)
  );

  operand_sequencer #(.IN_W(8), .OP_W(32), .N_OPS(3), .CMD_W(5)) u_sweep (
    .clk(clk), .rst(rst), .din(din8), .din_valid(dv8), .clear(1'b0),
    .op_bus(op8), .cmd(cmd8), .out_valid(ov8), .out_ready(1'b0),
    .res(32'h0), .res_valid(1'b0), .result(result8), .result_valid(rv8),
    .busy(busy8), .beat_idx(bi8)
  );

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".op_bus"}, op_bus, {m_ch[3], m_ch[2], m_ch[1], m_ch[0]});
    chk({tag, ".cmd"}, cmd, m_cmd);
    chk({tag, ".out_valid"}, out_valid, ph == 1);
    chk({tag, ".busy"}, busy, ph == 1 || ph == 2);
    chk({tag, ".beat_idx"}, beat_idx, m_n);
    chk({tag, ".result"}, result, m_res);
    chk({tag, ".result_valid"}, result_valid, m_rv);
  endtask

  // phases: 0 collecting beats, 1 offering, 2 awaiting result, 3 holding result
  task automatic cyc(input logic r, dv, input logic [15:0] d, input logic clr, ordy, rvv,
                     input logic [31:0] rs, input string tag);
    rst = r; din_valid = dv; din = d; clear = clr; out_ready = ordy; res_valid = rvv; res = rs;
    @(posedge clk);
    if (r) begin
      ph = 0; m_n = 0; m_cmd = 0; m_res = 0; m_rv = 0;
      for (int i = 0; i < 4; i++) m_ch[i] = 0;
    end else if (clr) begin
      ph = 0; m_n = 0;
    end else begin
      case (ph)
        0: if (dv) begin
          m_rv = 0;
          if (m_n < 4) begin m_ch[m_n] = d; m_n++; end
          else begin m_cmd = d[4:0]; m_n = 0; ph = 1; end
        end
        1: if (ordy) ph = 2;
        2: if (rvv) begin m_res = rs; m_rv = 1; ph = 3; end
        default: if (dv) begin m_ch[0] = d; m_n = 1; m_rv = 0; ph = 0; end
      endcase
    end
    #1;
    check_all(tag);
  endtask

  task automatic beat(input logic [15:0] d);
    cyc(0, 1, d, 0, 0, 0, 0, "beat");
  endtask

  initial begin
    total = 0; passed = 0;
    rst = 1; din_valid = 0; din = 0; clear = 0; out_ready = 0; res_valid = 0; res = 0;
    din8 = 0; dv8 = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, "reset");
    cyc(1, 1, 16'hFFFF, 1, 1, 1, 32'hFFFF_FFFF, "reset_hold");
    beat(16'h0000); beat(16'h40A8); beat(16'h0000); beat(16'h4194);
    chk("tp1.beat_idx_full", beat_idx, 4);
    beat(16'h0008);
    chk("tp1.op_bus", op_bus, 64'h4194_0000_40A8_0000);
    chk("tp1.cmd", cmd, 5'h08);
    chk("tp1.out_valid", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 16'($urandom), 0, 0, 1, $urandom, "issue_hold");
    chk("hold.op_bus", op_bus, 64'h4194_0000_40A8_0000);
    cyc(0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, "handshake_with_res");
    chk("hs.out_valid", out_valid, 1'b0);
    chk("hs.result_valid", result_valid, 1'b0);
    cyc(0, 1, 16'h5555, 0, 1, 0, 0, "wait_idle");
    cyc(0, 0, 0, 0, 0, 1, 32'h41BE_0000, "wait_res");
    chk("tp2.result", result, 32'h41BE_0000);
    chk("tp2.busy", busy, 1'b0);
    beat(16'h1234);
    chk("tp2.rv_cleared", result_valid, 1'b0);
    chk("tp2.op0_low", op_bus[15:0], 16'h1234);
    beat(16'h1111); beat(16'h2222);
    cyc(0, 1, 16'h3333, 1, 0, 0, 0, "clear_with_beat");
    chk("clr.beat_idx", beat_idx, 0);
    for (int i = 0; i < 4; i++) beat(16'($urandom));
    beat(16'h0015);
    cyc(0, 0, 0, 0, 1, 0, 0, "issue_one_cycle");
    chk("fast.out_valid", out_valid, 1'b0);
    cyc(0, 0, 0, 0, 0, 1, 32'hCAFE_F00D, "res2");
    cyc(0, 0, 0, 1, 0, 0, 0, "clear_in_done");
    chk("done_clr.rv_kept", result_valid, 1'b1);
    beat(16'hABCD);
    chk("done_clr.rv_dropped", result_valid, 1'b0);
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 99) == 0), 1'($urandom), 16'($urandom), ($urandom_range(0, 15) == 0),
          1'($urandom), 1'($urandom), $urandom, "random");
    cyc(0, 0, 0, 1, 0, 0, 0, "pre_wait_clear");
    for (int i = 0; i < 5; i++) beat(16'($urandom));
    cyc(0, 0, 0, 0, 1, 0, 0, "to_wait");
    chk("rstw.busy", busy, 1'b1);
    cyc(1, 0, 0, 0, 0, 0, 0, "rst_in_wait");
    chk("rstw.op_bus", op_bus, 64'h0);
    cyc(0, 0, 0, 0, 0, 1, 32'h1357_9BDF, "late_res");
    chk("rstw.result", result, 32'h0);
    for (int i = 1; i <= 12; i++) begin
      din8 = 8'(i); dv8 = 1;
      @(posedge clk); #1;
    end
    chk("sweep.beat_idx", bi8, 12);
    din8 = 8'h15;
    @(posedge clk); #1;
    dv8 = 0;
    chk("sweep.op_bus", op8, 96'h0C0B0A09_08070605_04030201);
    chk("sweep.cmd", cmd8, 5'h15);
    chk("sweep.out_valid", ov8, 1'b1);
    chk("sweep.beat_idx0", bi8, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
